// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-size and FSM state types for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    localparam int CNT_W = 3;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian lane steering for loads and stores; DMEM_ALIGN_FAULT_EN enables the misaligned flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        sign_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raw_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);
    logic [1:0]  lane;
    logic [31:0] shifted;

    // Halfword and word lanes are forced aligned; the fault build flags the original offset instead.
    always_comb begin
        lane    = size_i == SZ_HALF ? {addr_lo_i[1], 1'b0} : size_i == SZ_WORD ? 2'b00 : addr_lo_i;
        shifted = raw_i >> {lane, 3'b000};
        be_o    = size_i == SZ_BYTE ? 4'b0001 << lane :
                  size_i == SZ_HALF ? 4'b0011 << lane :
                  size_i == SZ_WORD ? 4'b1111 : 4'b0000;
        wword_o = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
                  size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o = size_i == SZ_BYTE ? {{24{sign_i & shifted[7]}}, shifted[7:0]} :
                  size_i == SZ_HALF ? {{16{sign_i & shifted[15]}}, shifted[15:0]} :
                  size_i == SZ_WORD ? shifted : 32'h0;
    end

`ifdef DMEM_ALIGN_FAULT_EN
    assign misaligned_o = (size_i == SZ_HALF && addr_lo_i[0]) || (size_i == SZ_WORD && addr_lo_i != 2'b00);
`else
    assign misaligned_o = 1'b0;
`endif
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked, wait-stated data memory with byte/half/word access; DMEM_ALIGN_FAULT_EN turns misalignment into an error.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = $clog2(DEPTH_WORDS);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              write_q;
    logic              sign_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic              req_ready_q;
    logic              rsp_valid_q;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]  word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic              range_err;
    logic              misaligned;
    logic              acc_err;
    logic              mem_we;
    logic [3:0]        be;
    logic [31:0]       wword;
    logic [31:0]       ld_data;
    logic [31:0]       raw;

    always_comb begin
        word_idx  = addr_q[ADDR_W-1:2];
        mem_idx   = word_idx[MEM_AW-1:0];
        range_err = 32'(word_idx) >= 32'(DEPTH_WORDS);
        raw       = range_err ? 32'h0 : mem_q[mem_idx];
        acc_err   = size_q == SZ_RSVD || range_err || misaligned;
        mem_we    = !rst && state_q == ST_ACCESS && write_q && !acc_err;
    end

    dmem_lane_align u_align (
        .size_i       (size_q),
        .addr_lo_i    (addr_q[1:0]),
        .sign_i       (sign_q),
        .wdata_i      (wdata_q),
        .raw_i        (raw),
        .be_o         (be),
        .wword_o      (wword),
        .rdata_o      (ld_data),
        .misaligned_o (misaligned)
    );

    // Storage is deliberately not reset; rst only gates the write enable.
    always_ff @(posedge clk)
        for (int b = 0; b < 4; b++)
            if (mem_we && be[b]) mem_q[mem_idx][b*8 +: 8] <= wword[b*8 +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            sign_q      <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:
                    if (req_valid) begin
                        write_q     <= req_write;
                        size_q      <= req_size;
                        sign_q      <= req_signed;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        cnt_q       <= CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
                        state_q     <= WAIT_CYCLES > 0 ? ST_WAIT : ST_ACCESS;
                    end
                ST_WAIT:
                    if (cnt_q == '0) state_q <= ST_ACCESS;
                    else cnt_q <= cnt_q - 1'b1;
                ST_ACCESS: begin
                    rsp_rdata_q <= (acc_err || write_q) ? 32'h0 : ld_data;
                    rsp_err_q   <= acc_err;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP:
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (WAIT_CYCLES=3 main instance, WAIT_CYCLES=0 latency instance).
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, rsp_ready = 1'b1;
    logic [1:0]  req_size = 2'b00;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0 = 1'b0, req_write0 = 1'b0, req_signed0 = 1'b0, rsp_ready0 = 1'b1;
    logic [1:0]  req_size0 = 2'b00;
    logic [15:0] req_addr0 = 16'h0;
    logic [31:0] req_wdata0 = 32'h0;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_e;

    dmem_responder #(.ADDR_W(16), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_W(16), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_size(req_size0), .req_signed(req_signed0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    // Scoreboard: every completed response handshake is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rsp: got err=%b rdata=%h, required no response", rsp_err, rsp_rdata);
            end else begin
                exp_e = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== exp_e) begin
                    fails++;
                    $display("FAIL rsp: got err=%b rdata=%h, required err=%b rdata=%h",
                             rsp_err, rsp_rdata, exp_e[32], exp_e[31:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [1:0] sz, input logic sg, input logic [15:0] a,
                        input logic [31:0] wd, input logic [31:0] erd, input logic eerr, input logic push);
        int n = 0;
        if (push) exp_q.push_back({eerr, erd});
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin step(); n++; end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: got req_ready=0 after %0d cycles, required 1", n);
            req_valid = 1'b0;
            return;
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b, required 1", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata: got %h, required 0", rsp_rdata); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err: got %b, required 0", rsp_err); end
        tests++; if (req_ready0 !== 1'b1) begin fails++; $display("FAIL reset_req_ready0: got %b, required 1", req_ready0); end
    endtask

    task automatic test_latency();
        int n = 0;
        int cyc;
        send(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        while (!req_ready && n < 50) begin step(); n++; end
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 30) begin step(); cyc++; end
        tests++; if (cyc !== 5) begin fails++; $display("FAIL latency_w3: got %0d cycles, required 5", cyc); end
        // WAIT_CYCLES=0 instance
        req_write0 = 1'b1; req_size0 = 2'b10; req_addr0 = 16'h0010; req_wdata0 = 32'hDEADBEEF; req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        n = 0;
        while (!req_ready0 && n < 50) begin step(); n++; end
        req_write0 = 1'b0; req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        cyc = 1;
        while (!rsp_valid0 && cyc < 30) begin step(); cyc++; end
        tests++; if (cyc !== 2) begin fails++; $display("FAIL latency_w0: got %0d cycles, required 2", cyc); end
        tests++; if (rsp_rdata0 !== 32'hDEADBEEF || rsp_err0 !== 1'b0) begin
            fails++; $display("FAIL load_w0: got err=%b rdata=%h, required err=0 rdata=deadbeef", rsp_err0, rsp_rdata0);
        end
    endtask

    task automatic test_lanes();
        send(1'b1, 2'b00, 1'b0, 16'h0013, 32'h000000A5, 32'h0, 1'b0, 1'b1);
        send(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b1);
        send(1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b1);
        send(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, 32'h000000A5, 1'b0, 1'b1);
        send(1'b0, 2'b01, 1'b1, 16'h0012, 32'h0, 32'hFFFFA5AD, 1'b0, 1'b1);
        send(1'b0, 2'b01, 1'b0, 16'h0010, 32'h0, 32'h0000BEEF, 1'b0, 1'b1);
        send(1'b0, 2'b01, 1'b1, 16'h0010, 32'h0, 32'hFFFFBEEF, 1'b0, 1'b1);
        send(1'b0, 2'b00, 1'b1, 16'h0011, 32'h0, 32'hFFFFFFBE, 1'b0, 1'b1);
        send(1'b0, 2'b00, 1'b0, 16'h0012, 32'h0, 32'h000000AD, 1'b0, 1'b1);
        send(1'b1, 2'b10, 1'b0, 16'h0014, 32'h0, 32'h0, 1'b0, 1'b1);
        send(1'b1, 2'b01, 1'b0, 16'h0016, 32'h1234CAFE, 32'h0, 1'b0, 1'b1);
        send(1'b0, 2'b10, 1'b0, 16'h0014, 32'h0, 32'hCAFE0000, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        int n = 0;
        while (!req_ready && n < 50) begin step(); n++; end
        rsp_ready = 1'b0;
        exp_q.push_back({1'b0, 32'hA5ADBEEF});
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 30) begin step(); n++; end
        exp_q.push_back({1'b0, 32'h000000A5});
        req_size = 2'b00; req_addr = 16'h0013; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'hA5ADBEEF || rsp_err !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: got valid=%b ready=%b rdata=%h err=%b, required valid=1 ready=0 rdata=a5adbeef err=0",
                         i, rsp_valid, req_ready, rsp_rdata, rsp_err);
            end
            step();
        end
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL backpressure_release: got valid=%b ready=%b, required valid=0 ready=1", rsp_valid, req_ready);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_errors();
        send(1'b1, 2'b10, 1'b0, 16'h0000, 32'h11111111, 32'h0, 1'b0, 1'b1);
        send(1'b0, 2'b11, 1'b0, 16'h0010, 32'h0, 32'h0, 1'b1, 1'b1);
        send(1'b1, 2'b11, 1'b0, 16'h0000, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        send(1'b1, 2'b10, 1'b0, 16'h1000, 32'h55555555, 32'h0, 1'b1, 1'b1);
        send(1'b0, 2'b10, 1'b0, 16'h1000, 32'h0, 32'h0, 1'b1, 1'b1);
        send(1'b0, 2'b00, 1'b0, 16'hFFFF, 32'h0, 32'h0, 1'b1, 1'b1);
        send(1'b0, 2'b10, 1'b0, 16'h0000, 32'h0, 32'h11111111, 1'b0, 1'b1);
    endtask

    task automatic test_misaligned();
`ifdef DMEM_ALIGN_FAULT_EN
        send(1'b0, 2'b10, 1'b0, 16'h0011, 32'h0, 32'h0, 1'b1, 1'b1);
        send(1'b0, 2'b01, 1'b0, 16'h0013, 32'h0, 32'h0, 1'b1, 1'b1);
        send(1'b1, 2'b01, 1'b0, 16'h0011, 32'h00007777, 32'h0, 1'b1, 1'b1);
        send(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b1);
`else
        send(1'b0, 2'b10, 1'b0, 16'h0011, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b1);
        send(1'b0, 2'b01, 1'b0, 16'h0013, 32'h0, 32'h0000A5AD, 1'b0, 1'b1);
        send(1'b1, 2'b01, 1'b0, 16'h0011, 32'h00007777, 32'h0, 1'b0, 1'b1);
        send(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hA5AD7777, 1'b0, 1'b1);
`endif
    endtask

    task automatic test_reset_mid();
        send(1'b1, 2'b10, 1'b0, 16'h0020, 32'h0, 32'h0, 1'b0, 1'b1);
        send(1'b1, 2'b10, 1'b0, 16'h0020, 32'h12345678, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_wait_rsp_valid: got %b, required 0", rsp_valid); end
        rst = 1'b0;
        step();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_wait_req_ready: got %b, required 1", req_ready); end
        send(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, 32'h0, 1'b0, 1'b1);
        send(1'b1, 2'b10, 1'b0, 16'h0020, 32'hABCDEF01, 32'h0, 1'b0, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_access_rsp_valid: got %b, required 0", rsp_valid); end
        send(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        int n = 0;
        test_reset();
        test_latency();
        test_lanes();
        test_backpressure();
        test_errors();
        test_misaligned();
        test_reset_mid();
        while (exp_q.size() != 0 && n < 200) begin step(); n++; end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d outstanding responses, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
